// File: rtl/reload_seq_pkg.sv
// Shared types for the reload sequencer: FSM states and the queued command format.
package reload_seq_pkg;

    localparam int COUNT_W = 4;
    localparam logic [COUNT_W-1:0] MAX_COUNT = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRE  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    typedef struct packed {
        logic               imm;
        logic [COUNT_W-1:0] val;
    } reload_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head_o peeks the oldest entry,
// rdata_o is the registered copy of the entry taken by the last pop.
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         rdata_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] rdata_q;
    logic             push_s;
    logic             pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign rdata_o = rdata_q;

    // occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // pointers, occupancy and read register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            rdata_q  <= {WIDTH{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rdata_q  <= mem_q[rd_ptr_q];
            end
        end
    end

    // storage array; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (push_s && !flush_i && !reset) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/reload_sequencer.sv
// Queues reload commands and issues each as a one-cycle load pulse to the
// counter, either immediately or on the counter's next wrap cycle.
module reload_sequencer #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [COUNT_W-1:0]       cmd_val_i,
    input  logic                     cmd_imm_i,
    input  logic                     flush_i,
    input  logic [COUNT_W-1:0]       count_i,
    output logic                     load_o,
    output logic [COUNT_W-1:0]       load_val_o,
    output logic [$clog2(DEPTH)+1:0] pending_o
);
    import reload_seq_pkg::*;

    localparam int PW = $clog2(DEPTH) + 2;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic             load_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [COUNT_W:0] head_s;
    logic [COUNT_W:0] rdata_s;
    logic             unused_s;

    assign cmd_ready_o = !full_s && !reset && !flush_i;
    assign push_s      = cmd_valid_i && cmd_ready_o;
    // S_IDLE sits between every pair of commands, capping issue rate at one per two cycles
    assign pop_s       = (state_q == S_IDLE) && !empty_s && !flush_i;

    sync_fifo #(
        .WIDTH (COUNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i ({cmd_imm_i, cmd_val_i}),
        .pop_i   (pop_s),
        .flush_i (flush_i),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (fifo_count_s),
        .head_o  (head_s),
        .rdata_o (rdata_s)
    );

    // next-state and load pulse; flush wins over every state
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
            load_s  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        state_d = head_s[COUNT_W] ? S_FIRE : S_ARMED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FIRE: begin
                    load_s  = 1'b1;
                    state_d = S_IDLE;
                end
                S_ARMED: begin
                    if (count_i == CNT_MAX) begin
                        load_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign load_o     = load_s && !reset;
    assign load_val_o = rdata_s[COUNT_W-1:0];
    assign pending_o  = PW'(fifo_count_s) + PW'(state_q != S_IDLE);
    assign unused_s   = ^{head_s[COUNT_W-1:0], rdata_s[COUNT_W]};

endmodule

// File: tb/tb_reload_sequencer.sv
// Bench for reload_sequencer: drives a model of the self-reloading counter
// from load_o and scoreboards every issued load value against the command stream.
module tb_reload_sequencer;
    import reload_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_imm = 1'b0;
    logic [3:0] cmd_val = 4'd0;
    logic       flush = 1'b0;
    logic [3:0] count;
    logic       cmd_ready;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] pending;

    reload_sequencer #(.DEPTH(4), .COUNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_val_i   (cmd_val),
        .cmd_imm_i   (cmd_imm),
        .flush_i     (flush),
        .count_i     (count),
        .load_o      (load),
        .load_val_o  (load_val),
        .pending_o   (pending)
    );

    always #5 clk = ~clk;

    // counter model: loads on load_o, otherwise counts up and reloads after 0xF
    logic [3:0] cnt_q = 4'd0;
    logic [3:0] reload_q = 4'd0;
    logic       cnt_set_en = 1'b0;
    logic [3:0] cnt_set_val = 4'd0;
    always @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 4'd0;
            reload_q <= 4'd0;
        end else if (cnt_set_en) begin
            cnt_q <= cnt_set_val;
        end else if (load) begin
            cnt_q    <= load_val;
            reload_q <= load_val;
        end else if (cnt_q == 4'hF) begin
            cnt_q <= reload_q;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end
    assign count = cnt_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int errs = 0;
    logic [3:0] exp_q[$];
    int load_cyc_q[$];
    int loads = 0;
    int last_load_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard: every load pulse must match the oldest outstanding command
    always @(negedge clk) begin
        if (!reset && load) begin
            loads++;
            last_load_cyc = cyc;
            load_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_load", 1, 0);
            end else begin
                chk("load_val", int'(load_val), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input int budget, output int c);
        int start;
        int n;
        start = loads;
        n = 0;
        while (loads == start && n < budget) begin
            tick();
            n++;
        end
        if (loads == start) chk("load_timeout", 0, 1);
        c = last_load_cyc;
    endtask

    typedef struct {
        logic       imm;
        logic [3:0] val;
        logic [3:0] start;
        int         lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        int c0;
        int c;
        int n;
        int i;
        int base;
        bit saw_full;
        reload_cmd_t b2b[6];

        vt[0] = '{1'b1, 4'h5, 4'h0, 2};
        vt[1] = '{1'b1, 4'h0, 4'h7, 2};
        vt[2] = '{1'b1, 4'hA, 4'hE, 2};
        vt[3] = '{1'b0, 4'h3, 4'hC, 4};
        vt[4] = '{1'b0, 4'h9, 4'hE, 2};
        vt[5] = '{1'b0, 4'h1, 4'hD, 3};
        vt[6] = '{1'b0, 4'hF, 4'h0, 16};
        vt[7] = '{1'b1, 4'hF, 4'h3, 2};

        // reset held three cycles
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_load", int'(load), 0);
            chk("rst_ready", int'(cmd_ready), 0);
            chk("rst_pending", int'(pending), 0);
            chk("rst_load_val", int'(load_val), 0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_rst", int'(cmd_ready), 1);
        tick();

        // single commands from idle: latency and value
        foreach (vt[k]) begin
            cmd_valid   = 1'b1;
            cmd_imm     = vt[k].imm;
            cmd_val     = vt[k].val;
            cnt_set_en  = 1'b1;
            cnt_set_val = vt[k].start;
            c0 = cyc;
            chk("ready_idle", int'(cmd_ready), 1);
            exp_q.push_back(vt[k].val);
            tick();
            cmd_valid  = 1'b0;
            cnt_set_en = 1'b0;
            chk("pending_one", int'(pending), 1);
            wait_load(40, c);
            chk("latency", c - c0, vt[k].lat);
            tick();
            tick();
            chk("pending_done", int'(pending), 0);
        end

        // back-to-back burst: first command waits for a wrap so the FIFO fills
        b2b[0] = '{imm: 1'b0, val: 4'h8};
        b2b[1] = '{imm: 1'b1, val: 4'h1};
        b2b[2] = '{imm: 1'b1, val: 4'h2};
        b2b[3] = '{imm: 1'b1, val: 4'h3};
        b2b[4] = '{imm: 1'b1, val: 4'h4};
        b2b[5] = '{imm: 1'b1, val: 4'h5};
        load_cyc_q.delete();
        base = loads;
        i = 0;
        n = 0;
        saw_full = 1'b0;
        cnt_set_val = 4'h0;
        while (i < 6 && n < 60) begin
            cmd_valid  = 1'b1;
            cmd_imm    = b2b[i].imm;
            cmd_val    = b2b[i].val;
            cnt_set_en = (n == 0);
            if (cmd_ready) begin
                exp_q.push_back(b2b[i].val);
                i++;
            end else if (!saw_full) begin
                saw_full = 1'b1;
                chk("pending_full", int'(pending), 5);
            end
            tick();
            n++;
        end
        cmd_valid  = 1'b0;
        cnt_set_en = 1'b0;
        chk("ready_dropped", int'(saw_full), 1);
        chk("all_accepted", i, 6);
        n = 0;
        while (loads < base + 6 && n < 60) begin
            tick();
            n++;
        end
        chk("b2b_loads", loads - base, 6);
        for (int k = 1; k < load_cyc_q.size(); k++) begin
            chk("b2b_spacing", load_cyc_q[k] - load_cyc_q[k-1], 2);
        end
        chk("sb_empty", exp_q.size(), 0);
        tick();
        tick();

        // flush in the cycle an armed command would have fired
        cmd_valid = 1'b1; cmd_imm = 1'b0; cmd_val = 4'h4;
        cnt_set_en = 1'b1; cnt_set_val = 4'hD;
        exp_q.push_back(4'h4);
        tick();
        cnt_set_en = 1'b0; cmd_imm = 1'b1; cmd_val = 4'h7;
        exp_q.push_back(4'h7);
        tick();
        cmd_val = 4'h8;
        exp_q.push_back(4'h8);
        tick();
        cmd_val = 4'h9;
        flush = 1'b1;
        #1;
        chk("flush_ready", int'(cmd_ready), 0);
        chk("flush_pending_pre", int'(pending), 3);
        chk("flush_count_at_max", int'(count), 15);
        chk("flush_load", int'(load), 0);
        exp_q.delete();
        base = loads;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_pending", int'(pending), 0);
        chk("flush_load_after", int'(load), 0);
        repeat (20) tick();
        chk("flush_no_loads", loads - base, 0);

        // 0xF loaded parks the counter; the following wrap command fires at once
        load_cyc_q.delete();
        base = loads;
        cmd_valid = 1'b1; cmd_imm = 1'b1; cmd_val = 4'hF;
        c0 = cyc;
        exp_q.push_back(4'hF);
        tick();
        cmd_imm = 1'b0; cmd_val = 4'h2;
        exp_q.push_back(4'h2);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (loads < base + 2 && n < 40) begin
            tick();
            n++;
        end
        chk("park_loads", loads - base, 2);
        if (load_cyc_q.size() >= 2) begin
            chk("park_first_lat", load_cyc_q[0] - c0, 2);
            chk("park_second_gap", load_cyc_q[1] - load_cyc_q[0], 2);
        end

        // reset mid-operation, together with flush
        tick();
        cmd_valid = 1'b1; cmd_imm = 1'b0; cmd_val = 4'h6;
        cnt_set_en = 1'b1; cnt_set_val = 4'h0;
        exp_q.push_back(4'h6);
        tick();
        cnt_set_en = 1'b0; cmd_imm = 1'b1; cmd_val = 4'h3;
        exp_q.push_back(4'h3);
        tick();
        cmd_valid = 1'b0;
        reset = 1'b1;
        flush = 1'b1;
        #1;
        chk("mid_rst_ready", int'(cmd_ready), 0);
        chk("mid_rst_load", int'(load), 0);
        tick();
        exp_q.delete();
        base = loads;
        chk("mid_rst_pending", int'(pending), 0);
        reset = 1'b0;
        flush = 1'b0;
        repeat (20) tick();
        chk("mid_rst_no_loads", loads - base, 0);
        cmd_valid = 1'b1; cmd_imm = 1'b1; cmd_val = 4'hA;
        c0 = cyc;
        exp_q.push_back(4'hA);
        tick();
        cmd_valid = 1'b0;
        wait_load(10, c);
        chk("post_rst_latency", c - c0, 2);
        tick();
        chk("final_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
